cordic_arbiter: RTL and testbench
=================================

Name: cordic_arbiter

Overview:
- Shares one CORDIC magnitude/angle pipeline among N_REQ AXI-Stream requesters.
- Round-robin arbitration on the CORDIC input; each accepted beat's source ID goes into a tag FIFO.
- Results leave the CORDIC in order, and each one is steered back to its source output using the FIFO head.
- Flushes the CORDIC after reset, because the CORDIC's valid pipeline has no reset.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, beat width: in = {y[31:16], x[15:0]}; out = {angle[31:16], mag[15:0]}.
- PIPE_LATENCY, 17, CORDIC input-to-output latency in cycles (input stage plus 16 iterations).
- TAG_DEPTH, 32, tag FIFO depth, power of 2, must be ≥ PIPE_LATENCY.
- LOCK_ON_PACKET, 0, when 1 the grant is held from a requester's first beat until its tlast beat is accepted.

Ports:
- s00_axis_aclk  in  1  clock
- s00_axis_aresetn  in  1  asynchronous active-low reset
- req_tdata  in  N_REQ*DATA_WIDTH  requester beats, requester k at slice k
- req_tvalid  in  N_REQ  per-requester valid
- req_tlast  in  N_REQ  per-requester last
- req_tready  out  N_REQ  per-requester ready
- rsp_tdata  out  DATA_WIDTH  result data, shared by all requesters
- rsp_tlast  out  1  result last
- rsp_tvalid  out  N_REQ  one-hot result valid, bit = destination requester
- rsp_tready  in  N_REQ  per-requester ready
- cordic_s_tdata  out  DATA_WIDTH  to CORDIC input
- cordic_s_tvalid  out  1  to CORDIC input
- cordic_s_tlast  out  1  to CORDIC input
- cordic_s_tready  in  1  from CORDIC (mirrors cordic_m_tready)
- cordic_m_tdata  in  DATA_WIDTH  from CORDIC output
- cordic_m_tvalid  in  1  from CORDIC output
- cordic_m_tlast  in  1  from CORDIC output
- cordic_m_tready  out  1  to CORDIC; stalls the whole CORDIC pipeline when low
- busy  out  1  high in FLUSH or when the tag FIFO is non-empty
- tag_err  out  1  sticky: a CORDIC result arrived with no tag

Behaviour:
- Reset, asynchronous on s00_axis_aresetn low:
  - state=FLUSH, flush counter=0, rr pointer=0, lock=0, FIFO empty, tag_err=0.
  - Outputs: req_tready=0, rsp_tvalid=0, cordic_s_tvalid=0, cordic_m_tready=1, busy=1.
- State machine:
  - FLUSH: cordic_s_tvalid=0, cordic_m_tready=1, every CORDIC output discarded.
  - The counter increments each cycle; at PIPE_LATENCY-1 the next state is RUN.
  - RUN has no exit except reset. A reset mid-operation drops all in-flight results and re-flushes.
- Arbitration (RUN only, combinational grant):
  - Eligible = req_tvalid. The grant is the first eligible index searching from rr pointer upward, wrapping.
  - If lock=1, the grant is forced to the locked index, even when that requester's tvalid is low.
  - can_issue = cordic_s_tready & ~fifo_full.
  - cordic_s_tvalid = can_issue & req_tvalid[grant]; cordic_s_tdata and cordic_s_tlast are muxed from grant.
  - req_tready[grant] = can_issue; all other req_tready bits = 0.
  - Fire = cordic_s_tvalid & cordic_s_tready. On fire, push grant into the tag FIFO.
  - With LOCK_ON_PACKET=0: on fire, rr ← grant+1 mod N_REQ.
  - With LOCK_ON_PACKET=1: on fire with tlast=0, set lock to grant. On fire with tlast=1, clear lock and set rr ← grant+1.
- Return path (RUN):
  - head = FIFO head tag; have_tag = ~fifo_empty.
  - rsp_tvalid[head] = cordic_m_tvalid & have_tag; other bits 0.
  - rsp_tdata and rsp_tlast pass through from the CORDIC output.
  - cordic_m_tready = ~cordic_m_tvalid | ~have_tag | rsp_tready[head]. Bubbles never stall; only the head's destination back-pressures.
  - Pop on cordic_m_tvalid & have_tag & cordic_m_tready.
  - cordic_m_tvalid & ~have_tag → beat discarded, tag_err ← 1.
- Tag FIFO:
  - Registered pointers; simultaneous push and pop are legal at any occupancy.
  - Push is never attempted when full, because it is gated by can_issue.
  - FIFO full → no beat issued, req_tready all 0.
- Latency: request to response = PIPE_LATENCY cycles of cordic_m_tready=1. There is no added register stage.
- Ordering: responses are returned in issue order.

Decomposition:
- Package cordic_arb_pkg: ID width localparam ($clog2(N_REQ)) and state enum {FLUSH, RUN}.
- One sub-module, tag_fifo (synchronous FIFO, width=ID width, depth=TAG_DEPTH, async active-low reset).
- Round-robin grant logic stays inline.

Test Plan:
- Reset then idle: busy=1 for exactly 17 cycles, then 0. cordic_s_tvalid=0 and rsp_tvalid=0 throughout. A CORDIC model primed with a garbage tvalid produces no rsp_tvalid and tag_err stays 0.
- Single request: req1 sends {y=0, x=100} → rsp_tvalid=4'b0010 exactly 17 cycles later, mag≈100, angle=0. busy drops the cycle after the pop.
- All four requesters valid continuously, LOCK_ON_PACKET=0 → issue order 0,1,2,3,0,… one beat per cycle. Responses follow the same order, with rsp_tvalid bits rotating.
- Back-pressure: rsp_tready[2]=0 while req2's result is at the head → cordic_m_tready=0 and the CORDIC freezes. After 5 cycles rsp_tready[2]=1 → the result is delivered with no loss or duplication.
- LOCK_ON_PACKET=1: req0 sends a 3-beat packet with req0 tvalid low for 2 cycles mid-packet, while req3 stays valid → req3 gets no grant until req0's tlast is accepted, then req3 is granted.
- Reset asserted with 10 results in flight → outputs return to reset values immediately, the FIFO empties, and 17 FLUSH cycles discard the stale results. The first post-flush request returns correctly.

Source files
------------

// File: rtl/cordic_arb_pkg.sv
// rtl/cordic_arb_pkg.sv - shared types for the CORDIC requester arbiter
package cordic_arb_pkg;

    localparam int MAX_REQ = 8;
    // Requester IDs are sized for the largest supported N_REQ.
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/cordic_arbiter_tag_fifo.sv
// rtl/cordic_arbiter_tag_fifo.sv - synchronous FIFO holding source IDs of in-flight CORDIC beats
module tag_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign wr_d = push_i ? wr_q + 1'b1 : wr_q;
    assign rd_d = pop_i  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin sharing of one CORDIC pipeline with tag-steered returns
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int PIPE_LATENCY   = 17,
    parameter int TAG_DEPTH      = 32,
    parameter int LOCK_ON_PACKET = 0
) (
    input  logic                        s00_axis_aclk,
    input  logic                        s00_axis_aresetn,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_tdata,
    input  logic [N_REQ-1:0]            req_tvalid,
    input  logic [N_REQ-1:0]            req_tlast,
    output logic [N_REQ-1:0]            req_tready,
    output logic [DATA_WIDTH-1:0]       rsp_tdata,
    output logic                        rsp_tlast,
    output logic [N_REQ-1:0]            rsp_tvalid,
    input  logic [N_REQ-1:0]            rsp_tready,
    output logic [DATA_WIDTH-1:0]       cordic_s_tdata,
    output logic                        cordic_s_tvalid,
    output logic                        cordic_s_tlast,
    input  logic                        cordic_s_tready,
    input  logic [DATA_WIDTH-1:0]       cordic_m_tdata,
    input  logic                        cordic_m_tvalid,
    input  logic                        cordic_m_tlast,
    output logic                        cordic_m_tready,
    output logic                        busy,
    output logic                        tag_err
);

    localparam int CNT_W = $clog2(PIPE_LATENCY + 1);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [ID_W-1:0]   rr_q, lock_id_q;
    logic              lock_q, tag_err_q;

    logic [2*N_REQ-1:0]    dbl;
    logic                  found;
    logic [ID_W-1:0]       grant, rr_next, head;
    logic [N_REQ-1:0]      gnt_oh, head_oh;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid, sel_last, head_ready;
    logic                  run, can_issue, fire, have_tag, pop, fifo_full, fifo_empty;

    // Rotating priority search starting at rr_q; an active packet lock overrides it.
    always_comb begin
        dbl   = {req_tvalid, req_tvalid} >> rr_q;
        grant = rr_q;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                grant = (int'(rr_q) + i >= N_REQ) ? ID_W'(int'(rr_q) + i - N_REQ)
                                                  : ID_W'(int'(rr_q) + i);
            end
        end
        if (lock_q) grant = lock_id_q;
    end

    always_comb begin
        sel_data   = '0;
        gnt_oh     = '0;
        head_oh    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            gnt_oh[k]  = (grant == ID_W'(k));
            head_oh[k] = (head == ID_W'(k));
            if (gnt_oh[k]) sel_data = req_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
        sel_valid  = |(req_tvalid & gnt_oh);
        sel_last   = |(req_tlast & gnt_oh);
        head_ready = |(rsp_tready & head_oh);
    end

    assign rr_next   = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    assign run       = (state_q == RUN);
    assign can_issue = run & cordic_s_tready & ~fifo_full;
    assign fire      = cordic_s_tvalid & cordic_s_tready;
    assign have_tag  = ~fifo_empty;

    assign cordic_s_tvalid = can_issue & sel_valid;
    assign cordic_s_tdata  = sel_data;
    assign cordic_s_tlast  = sel_last;
    assign req_tready      = can_issue ? gnt_oh : '0;

    // Untagged beats and flush garbage are drained freely; only a tagged head can stall.
    assign cordic_m_tready = ~run | ~cordic_m_tvalid | ~have_tag | head_ready;
    assign pop             = run & cordic_m_tvalid & have_tag & cordic_m_tready;
    assign rsp_tvalid      = (run & cordic_m_tvalid & have_tag) ? head_oh : '0;
    assign rsp_tdata       = cordic_m_tdata;
    assign rsp_tlast       = cordic_m_tlast;
    assign busy            = ~run | have_tag;
    assign tag_err         = tag_err_q;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            case (state_q)
                FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                    if (flush_cnt_q == CNT_W'(PIPE_LATENCY - 1)) state_q <= RUN;
                end
                RUN: begin
                    if (fire) begin
                        if (LOCK_ON_PACKET != 0) begin
                            if (sel_last) begin
                                lock_q <= 1'b0;
                                rr_q   <= rr_next;
                            end else begin
                                lock_q    <= 1'b1;
                                lock_id_q <= grant;
                            end
                        end else begin
                            rr_q <= rr_next;
                        end
                    end
                    if (cordic_m_tvalid && !have_tag) tag_err_q <= 1'b1;
                end
                default: state_q <= FLUSH;
            endcase
        end
    end

    tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i   (s00_axis_aclk),
        .rst_ni  (s00_axis_aresetn),
        .push_i  (fire),
        .data_i  (grant),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - directed vector bench for cordic_arbiter with a latency-only CORDIC stand-in
module tb_cordic_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic prime = 1'b0;
    always #5 clk = ~clk;

    logic [N*DW-1:0] req_tdata  = '0;
    logic [N-1:0]    req_tvalid = '0;
    logic [N-1:0]    req_tlast  = '1;
    logic [N-1:0]    rsp_tready = '1;

    logic [N-1:0]  req_tready [2];
    logic [DW-1:0] rsp_tdata  [2];
    logic          rsp_tlast  [2];
    logic [N-1:0]  rsp_tvalid [2];
    logic [DW-1:0] cs_tdata   [2];
    logic          cs_tvalid  [2];
    logic          cs_tlast   [2];
    logic [DW-1:0] cm_tdata   [2];
    logic          cm_tvalid  [2];
    logic          cm_tlast   [2];
    logic          cm_tready  [2];
    logic          busy       [2];
    logic          tag_err    [2];

    // Instance 0: LOCK_ON_PACKET=0, instance 1: LOCK_ON_PACKET=1; both see the same stimulus.
    for (genvar g = 0; g < 2; g++) begin : u
        cordic_arbiter #(
            .N_REQ(N), .DATA_WIDTH(DW), .PIPE_LATENCY(L), .TAG_DEPTH(32), .LOCK_ON_PACKET(g)
        ) dut (
            .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
            .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast),
            .req_tready(req_tready[g]),
            .rsp_tdata(rsp_tdata[g]), .rsp_tlast(rsp_tlast[g]), .rsp_tvalid(rsp_tvalid[g]),
            .rsp_tready(rsp_tready),
            .cordic_s_tdata(cs_tdata[g]), .cordic_s_tvalid(cs_tvalid[g]), .cordic_s_tlast(cs_tlast[g]),
            .cordic_s_tready(cm_tready[g]),
            .cordic_m_tdata(cm_tdata[g]), .cordic_m_tvalid(cm_tvalid[g]), .cordic_m_tlast(cm_tlast[g]),
            .cordic_m_tready(cm_tready[g]),
            .busy(busy[g]), .tag_err(tag_err[g])
        );

        logic [L-1:0]  pv, pl;
        logic [DW-1:0] pd [L];
        always @(posedge clk) begin
            if (prime) begin
                pv <= '1;
                pl <= '1;
                for (int i = 0; i < L; i++) pd[i] <= 32'hbad0_0000 + 32'(i);
            end else if (cm_tready[g]) begin
                pv    <= {pv[L-2:0], cs_tvalid[g]};
                pl    <= {pl[L-2:0], cs_tlast[g]};
                pd[0] <= cs_tdata[g];
                for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
            end
        end
        assign cm_tvalid[g] = pv[L-1];
        assign cm_tlast[g]  = pl[L-1];
        assign cm_tdata[g]  = pd[L-1];
    end

    int n_vec = 0;
    int n_err = 0;
    logic [3:0]  q_vld [$];
    logic [31:0] q_dat [$];

    typedef struct {
        int          src;
        logic [31:0] data;
        logic [3:0]  exp_vld;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic [3:0] exp_ready;
        logic       exp_csv;
    } lk_t;

    vec_t vecs [4];
    lk_t  lks  [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beat(input int c, input int k);
        return 32'h1000_0000 + 32'(c * 16 + k);
    endfunction

    task automatic reset_check();
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_tready", req_tready[i], 0);
            chk("rst_rsp_tvalid", rsp_tvalid[i], 0);
            chk("rst_cs_tvalid", cs_tvalid[i], 0);
            chk("rst_cm_tready", cm_tready[i], 1);
            chk("rst_busy", busy[i], 1);
            chk("rst_tag_err", tag_err[i], 0);
        end
    endtask

    task automatic flush_check();
        int   cnt;
        logic seen;
        cnt  = 0;
        seen = 1'b0;
        while (busy[0] && cnt < 100) begin
            seen |= (rsp_tvalid[0] != 0) | cs_tvalid[0] | (rsp_tvalid[1] != 0) | cs_tvalid[1];
            cnt++;
            tick();
        end
        chk("flush_busy_cycles", cnt, L);
        chk("flush_quiet", seen, 0);
        chk("flush_busy1_low", busy[1], 0);
        tick();
        tick();
        chk("flush_tag_err0", tag_err[0], 0);
        chk("flush_tag_err1", tag_err[1], 0);
    endtask

    task automatic single(input int src, input logic [31:0] data,
                          input logic [3:0] exp_vld, input logic [31:0] exp_data);
        logic [3:0] oh;
        int lat;
        oh = 4'b0001 << src;
        req_tdata = '0;
        req_tdata[src*DW +: DW] = data;
        req_tvalid = oh;
        req_tlast  = '1;
        #1;
        chk("single_ready", req_tready[0], oh);
        tick();
        req_tvalid = '0;
        #1;
        lat = 1;
        while (rsp_tvalid[0] == 0 && lat < 40) begin
            tick();
            lat++;
        end
        chk("single_latency", lat, L);
        for (int i = 0; i < 2; i++) begin
            chk("single_rsp_tvalid", rsp_tvalid[i], exp_vld);
            chk("single_rsp_tdata", rsp_tdata[i], exp_data);
        end
        chk("single_busy_at_rsp", busy[0], 1);
        tick();
        chk("single_busy_after_pop", busy[0], 0);
    endtask

    task automatic drain(input int idx, input int max);
        int cyc;
        cyc = 0;
        while (q_vld.size() > 0 && cyc < max) begin
            if (rsp_tvalid[idx] != 0) begin
                chk("order_rsp_tvalid", rsp_tvalid[idx], q_vld.pop_front());
                chk("order_rsp_tdata", rsp_tdata[idx], q_dat.pop_front());
            end
            tick();
            cyc++;
        end
        chk("order_all_returned", q_vld.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d [4];
        int lat;
        int cyc;
        logic seen;

        vecs[0] = '{1, 32'h0000_0064, 4'b0010, 32'h0000_0064};
        vecs[1] = '{0, 32'h0005_0003, 4'b0001, 32'h0005_0003};
        vecs[2] = '{2, 32'h7fff_8001, 4'b0100, 32'h7fff_8001};
        vecs[3] = '{3, 32'h1234_abcd, 4'b1000, 32'h1234_abcd};

        lks[0] = '{4'b1001, 4'b1000, 4'b0001, 1'b1};
        lks[1] = '{4'b1000, 4'b1000, 4'b0001, 1'b0};
        lks[2] = '{4'b1000, 4'b1000, 4'b0001, 1'b0};
        lks[3] = '{4'b1001, 4'b1000, 4'b0001, 1'b1};
        lks[4] = '{4'b1001, 4'b1001, 4'b0001, 1'b1};
        lks[5] = '{4'b1000, 4'b1001, 4'b1000, 1'b1};
        lks[6] = '{4'b0000, 4'b1001, 4'b0001, 1'b0};

        // Reset, then prime the CORDIC stand-in with garbage on the edge before release.
        #2 rst_n = 1'b0;
        #1;
        reset_check();
        prime = 1'b1;
        tick();
        prime = 1'b0;
        rst_n = 1'b1;
        flush_check();

        for (int v = 0; v < 4; v++)
            single(vecs[v].src, vecs[v].data, vecs[v].exp_vld, vecs[v].exp_data);

        // All requesters valid continuously: strict rotation from rr=0.
        req_tvalid = '1;
        req_tlast  = '1;
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < N; k++) req_tdata[k*DW +: DW] = beat(c, k);
            #1;
            chk("rr_grant", req_tready[0], 4'b0001 << (c % 4));
            chk("rr_issue", cs_tvalid[0], 1);
            q_vld.push_back(4'b0001 << (c % 4));
            q_dat.push_back(beat(c, c % 4));
            tick();
        end
        req_tvalid = '0;
        #1;
        drain(0, 60);

        // Back-pressure on requester 2 while its result is at the head.
        req_tvalid = '1;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < N; k++) req_tdata[k*DW +: DW] = beat(100 + c, k);
            d[c] = beat(100 + c, c);
            #1;
            chk("bp_grant", req_tready[0], 4'b0001 << c);
            tick();
        end
        req_tvalid = '0;
        rsp_tready = 4'b1011;
        #1;
        lat = 4;
        while (rsp_tvalid[0] == 0 && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp_first_latency", lat, L);
        chk("bp_rsp0", rsp_tvalid[0], 4'b0001);
        chk("bp_dat0", rsp_tdata[0], d[0]);
        tick();
        chk("bp_rsp1", rsp_tvalid[0], 4'b0010);
        chk("bp_dat1", rsp_tdata[0], d[1]);
        tick();
        chk("bp_rsp2_held", rsp_tvalid[0], 4'b0100);
        chk("bp_stall", cm_tready[0], 0);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("bp_frozen_vld", rsp_tvalid[0], 4'b0100);
            chk("bp_frozen_stall", cm_tready[0], 0);
        end
        rsp_tready = '1;
        #1;
        chk("bp_release", cm_tready[0], 1);
        chk("bp_dat2", rsp_tdata[0], d[2]);
        tick();
        chk("bp_rsp3", rsp_tvalid[0], 4'b1000);
        chk("bp_dat3", rsp_tdata[0], d[3]);
        tick();
        chk("bp_no_dup", rsp_tvalid[0], 0);
        chk("bp_idle", busy[0], 0);

        // Packet lock on instance 1: req3 waits for req0's tlast.
        for (int i = 0; i < 7; i++) begin
            req_tvalid = lks[i].valid;
            req_tlast  = lks[i].last;
            for (int k = 0; k < N; k++) req_tdata[k*DW +: DW] = beat(200 + i, k);
            #1;
            chk("lock_ready", req_tready[1], lks[i].exp_ready);
            chk("lock_s_tvalid", cs_tvalid[1], lks[i].exp_csv);
            if (lks[i].exp_csv) begin
                q_vld.push_back(lks[i].exp_ready);
                q_dat.push_back(beat(200 + i, lks[i].exp_ready[3] ? 3 : 0));
            end
            tick();
        end
        req_tvalid = '0;
        req_tlast  = '1;
        #1;
        drain(1, 60);
        cyc = 0;
        while ((busy[0] || busy[1]) && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("lock_idle", busy[0] | busy[1], 0);

        // Reset with 10 results in flight.
        req_tvalid = '1;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < N; k++) req_tdata[k*DW +: DW] = beat(300 + c, k);
            tick();
        end
        rst_n = 1'b0;
        #1;
        reset_check();
        tick();
        tick();
        req_tvalid = '0;
        rst_n = 1'b1;
        flush_check();
        single(2, 32'h0000_0042, 4'b0100, 32'h0000_0042);

        // Untagged CORDIC output in RUN: discarded, tag_err sticks.
        prime = 1'b1;
        tick();
        prime = 1'b0;
        #1;
        chk("tagerr_no_rsp", rsp_tvalid[0], 0);
        chk("tagerr_not_stalled", cm_tready[0], 1);
        tick();
        chk("tagerr_set0", tag_err[0], 1);
        chk("tagerr_set1", tag_err[1], 1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            seen |= (rsp_tvalid[0] != 0) | (rsp_tvalid[1] != 0);
            tick();
        end
        chk("tagerr_discarded", seen, 0);
        chk("tagerr_sticky", tag_err[0], 1);
        chk("tagerr_not_busy", busy[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
